// File: rtl/uart_buffered_tx_pkg.sv
// Shared definitions for the buffered UART transmitter: store address,
// default bit timing, FSM state encodings and the write request struct.
package uart_buffered_tx_pkg;

    localparam logic [31:0] UART_ADDR        = 32'h8000_0000;
    localparam int          CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef struct packed {
        logic       wr;
        logic [7:0] dat;
    } tx_req_t;

endpackage

// File: rtl/uart_buffered_tx_if.sv
// Store-side handshake of the buffered UART: byte writes in, status flags out.
interface uart_buffered_tx_if;
    logic       wr_i;
    logic [7:0] dat_i;
    logic       full_o;
    logic       busy_o;
    logic       overflow_o;

    modport master (output wr_i, dat_i, input  full_o, busy_o, overflow_o);
    modport slave  (input  wr_i, dat_i, output full_o, busy_o, overflow_o);
endinterface

// File: rtl/uart_buffered_tx_fifo.sv
// Synchronous FIFO with registered count/full/empty; push when full and
// pop when empty are ignored.
module tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;
    logic          do_push, do_pop;

    // Full is judged on the registered flag, so a pop on the same edge
    // does not make room for a write.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop FSM,
// back-to-back frames with no idle gap while data is queued.
module uart_buffered_tx
    import uart_buffered_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DEPTH        = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_buffered_tx_if.slave  bus,
    output logic               uart_tx
);
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_req_t                 req;
    logic [7:0]              head;
    logic [$clog2(DEPTH):0]  count;
    logic                    full, empty;

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          ovf;
    logic          baud_done;
    logic          pop;

    assign req = '{wr: bus.wr_i, dat: bus.dat_i};

    tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req.wr),
        .din   (req.dat),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign baud_done = (baud == BAUD_LAST);
    assign pop = !empty && ((state == ST_IDLE) || (state == ST_STOP && baud_done));

    assign bus.full_o     = full;
    assign bus.busy_o     = (count != '0) || (state != ST_IDLE);
    assign bus.overflow_o = ovf;

    // uart_tx is loaded with the level of the state being entered, so the
    // line changes on the same edge as the state and comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            if (req.wr && full) ovf <= 1'b1;
            case (state)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    baud    <= '0;
                    if (pop) begin
                        shift   <= head;
                        state   <= ST_START;
                        uart_tx <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        uart_tx <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= ST_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift   <= head;
                            state   <= ST_START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= ST_IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Directed + random bench for uart_buffered_tx; a queue/frame-timer model
// predicts the line level and status flags every cycle.
module tb_uart_buffered_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;

    uart_buffered_tx_if bus();

    uart_buffered_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queued bytes, byte on the wire, cycles left in the current frame.
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         frame_left = 0;
    logic       m_ovf = 1'b0;

    function automatic logic exp_line(input int left, input logic [7:0] b);
        int p, slot;
        if (left == 0) return 1'b1;
        p    = FRAME - left;
        slot = p / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic w, input logic [7:0] d, input logic r);
        logic pop_now, full_pre;
        bus.wr_i  = w;
        bus.dat_i = d;
        rst       = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            frame_left = 0;
            m_ovf      = 1'b0;
        end else begin
            full_pre = (q.size() == DEPTH);
            pop_now  = (q.size() != 0) && (frame_left <= 1);
            if (w && full_pre) m_ovf = 1'b1;
            if (pop_now) cur = q.pop_front();
            if (w && !full_pre) q.push_back(d);
            if (pop_now) frame_left = FRAME;
            else if (frame_left > 0) frame_left--;
        end
        #1;
        chk("uart_tx",    uart_tx,            exp_line(frame_left, cur));
        chk("busy_o",     bus.busy_o,         (q.size() != 0) || (frame_left != 0));
        chk("full_o",     bus.full_o,         q.size() == DEPTH);
        chk("overflow_o", bus.overflow_o,     m_ovf);
        chk("count",      dut.u_fifo.count,   q.size());
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int guard;
        bus.wr_i  = 1'b0;
        bus.dat_i = 8'h00;
        rst       = 1'b1;

        // Reset state
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", bus.busy_o, 0);

        // Single frame 0x55
        tick(1'b1, 8'h55, 1'b0);
        idle(50);

        // Two back-to-back frames
        tick(1'b1, 8'hA5, 1'b0);
        tick(1'b1, 8'h3C, 1'b0);
        idle(90);

        // Write at count=1 on the pop edge: count holds at 1
        tick(1'b1, 8'h42, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        chk("cnt_hold", dut.u_fifo.count, 1);
        idle(90);

        // Fill while a frame is in flight; 17th write dropped
        tick(1'b1, 8'h80, 1'b0);
        idle(2);
        for (int i = 0; i <= 16; i++) tick(1'b1, 8'(i), 1'b0);
        chk("ovf_fill", bus.overflow_o, 1);
        chk("full_fill", bus.full_o, 1);
        idle(17 * FRAME + 10);

        // Write on the same edge as a pop with the FIFO full
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h81, 1'b0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
        guard = 0;
        while (!(frame_left == 1 && q.size() == DEPTH) && guard < 200) begin
            idle(1);
            guard++;
        end
        chk("wait_pop_edge", guard < 200, 1);
        tick(1'b1, 8'hAA, 1'b0);
        chk("aa_count", dut.u_fifo.count, DEPTH - 1);
        chk("aa_ovf", bus.overflow_o, 1);
        idle(100);

        // Reset during DATA bit 3 of 0xFF with bytes queued
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        tick(1'b1, 8'h33, 1'b0);
        guard = 0;
        while (frame_left != FRAME - 4 * CPB - 2 && guard < 100) begin
            idle(1);
            guard++;
        end
        chk("wait_bit3", guard < 100, 1);
        tick(1'b0, 8'h00, 1'b1);
        chk("mid_rst_tx", uart_tx, 1);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_full", bus.full_o, 0);
        chk("mid_rst_ovf", bus.overflow_o, 0);
        idle(100);

        // Random writes, enough to overflow now and then
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 15) == 0, 8'($urandom), 1'b0);
        idle(DEPTH * FRAME + 50);
        chk("drained_busy", bus.busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
